// File: rtl/sr596_if.sv
// Bus between the sr596 chain loader and its user: the parallel-word
// handshake, the readback word, and the pins of the shift-register chain.
interface sr596_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             dvalid;
  logic             dready;
  logic             clr_req;
  logic             oe;
  logic             qh_in;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             ser;
  logic             sck;
  logic             rck;
  logic             sclr;
  logic             g;

  // User / board side: supplies words, control requests and the chain's qh.
  modport master (
    output din, dvalid, clr_req, oe, qh_in,
    input  dready, rdata, rvalid, ser, sck, rck, sclr, g
  );

  // Loader side.
  modport slave (
    input  din, dvalid, clr_req, oe, qh_in,
    output dready, rdata, rvalid, ser, sck, rck, sclr, g
  );
endinterface

// File: rtl/sr596_loader.sv
// Serializer for a daisy chain of 8-bit shift/storage register devices.
// A word accepted on the valid/ready handshake is shifted out MSB first on
// ser/sck, then latched into the device outputs with an rck pulse. The old
// chain contents come back on qh_in during the shift and are reported on
// rdata. A clear request pulses sclr low; g follows ~oe one cycle later.
module sr596_loader #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2
) (
  input  logic clk,
  input  logic rst,
  sr596_if.slave bus
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SLO, SHI, LATCH, CLR} state_t;

  state_t           state;
  logic [DCW-1:0]   div_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             ser;
  logic             sck;
  logic             rck;
  logic             sclr;
  logic             g;
  logic             dready;
  logic             accept;
  logic             phase_end;
  logic             shift_step;

  // Append one readback bit on the LSB side; written without part-selects
  // so a single-bit chain still elaborates.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w,
                                                input logic b);
    return (w << 1) | WIDTH'(b);
  endfunction

  // dready is only high in IDLE, and clr_req wins over dvalid.
  assign accept     = (state == IDLE) && dready && !bus.clr_req && bus.dvalid;
  assign phase_end  = (div_cnt == DIV_LAST);
  assign shift_step = (state == SHI) && phase_end;
  assign sh_next    = shreg << 1;

  // Word being shifted out; data path only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= bus.din;
    end else if (shift_step) begin
      shreg <= sh_next;
    end
  end

  // Control FSM with registered chain pins, handshake and readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      rck     <= 1'b0;
      ser     <= 1'b0;
      sclr    <= 1'b0;
      dready  <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          sclr   <= 1'b1;
          dready <= 1'b1;
          if (dready && bus.clr_req) begin
            state   <= CLR;
            sclr    <= 1'b0;
            dready  <= 1'b0;
            div_cnt <= '0;
          end else if (accept) begin
            state   <= SLO;
            ser     <= bus.din[WIDTH-1];
            dready  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SLO: begin
          if (phase_end) begin
            // sck rises on this edge; qh_in still shows the bit the chain
            // is about to shift out, starting with the old MSB.
            state   <= SHI;
            sck     <= 1'b1;
            rdata   <= shift_in(rdata, bus.qh_in);
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHI: begin
          if (phase_end) begin
            sck     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state  <= LATCH;
              rck    <= 1'b1;
              rvalid <= 1'b1;
            end else begin
              state <= SLO;
              ser   <= sh_next[WIDTH-1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (phase_end) begin
            state   <= IDLE;
            rck     <= 1'b0;
            dready  <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        CLR: begin
          if (phase_end) begin
            state   <= IDLE;
            sclr    <= 1'b1;
            dready  <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output enable simply follows the request, active-low, one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      g <= 1'b1;
    end else begin
      g <= ~bus.oe;
    end
  end

  assign bus.dready = dready;
  assign bus.rdata  = rdata;
  assign bus.rvalid = rvalid;
  assign bus.ser    = ser;
  assign bus.sck    = sck;
  assign bus.rck    = rck;
  assign bus.sclr   = sclr;
  assign bus.g      = g;

endmodule

// File: doc/sr596_loader.md
Name: sr596_loader

Overview:
Synchronous serializer that drives one or more daisy-chained 8-bit shift/output-register devices (ser/sck/rck/sclr/g pin set, open-collector outputs). It accepts a parallel word over a valid/ready handshake and shifts it out MSB first on ser/sck. It then pulses rck to transfer the word into the device output register. It also captures the previous chain contents from the last device's qh pin as a readback word, and provides chain clear and output-enable control.

Parameters:
WIDTH, 8, bits per transaction (8 × number of chained devices); legal range 1..64.
DIV, 2, clk cycles per sck/rck/sclr phase; DIV=0 is illegal.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
din  input  WIDTH  parallel word to load.
dvalid  input  1  din valid.
dready  output  1  loader idle and able to accept.
clr_req  input  1  request chain shift-register clear (sampled only in IDLE).
oe  input  1  output-enable request, active-high.
qh_in  input  1  serial output of last chain device; board provides pullup.
rdata  output  WIDTH  previous chain contents captured during the last transaction.
rvalid  output  1  one-cycle pulse when rdata is updated.
ser  output  1  serial data to chain.
sck  output  1  shift clock; chain shifts on rising edge.
rck  output  1  storage clock; chain stores on rising edge.
sclr  output  1  chain shift-register clear, active-low.
g  output  1  chain output enable, active-low.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, sck=0, rck=0, ser=0, sclr=0 (chain cleared while reset held), g=1, dready=0, rvalid=0, rdata=0; all counters cleared. First edge with rst=0: sclr=1, dready=1.
- Reset mid-transaction aborts immediately (next edge); rck is never pulsed for an aborted word, so the device output register keeps its old value.
- g: registered ~oe, 1-cycle latency; independent of state; unchanged by transactions.
- FSM states: IDLE, SLO, SHI, LATCH, CLR.
- IDLE: dready=1.
  - clr_req=1 -> CLR (clr_req has priority over dvalid on the same edge; the word is not accepted).
  - else dvalid=1 -> capture din into shift reg, bit counter=0, -> SLO.
  - dvalid while dready=0 is ignored; din changes after accept are ignored.
- SLO: sck=0, ser=shreg[WIDTH-1]; held DIV cycles, then -> SHI.
- SHI: sck=1 (rising edge at first SHI cycle), ser held.
  - On the SLO->SHI edge, sample qh_in into rdata LSB side (rdata <= {rdata[WIDTH-2:0], qh_in}). The first sample is the old chain MSB.
  - After DIV cycles: shreg shifts left, bit counter++.
  - If counter reaches WIDTH -> LATCH, else -> SLO.
- LATCH: sck=0, rck=1 for DIV cycles; rvalid=1 in the first LATCH cycle only; then rck=0, -> IDLE.
- CLR: sclr=0 for DIV cycles, then sclr=1, -> IDLE. sck/rck stay 0; storage register unaffected.
- Timing for an accept at edge k:
  - ser valid from cycle k+1.
  - sck rise n (n=0..WIDTH-1) at cycle k+1+DIV+2·DIV·n.
  - rck rise at k+1+2·DIV·WIDTH.
  - dready=1 again at k+1+(2·WIDTH+1)·DIV.
  - Back-to-back accept period = 1+(2·WIDTH+1)·DIV cycles.
- Bit order: the first bit shifted ends at the chain's highest output, so din[WIDTH-1] appears on the last device's q[7] and din[0] on the first device's q[0].
- Chain clear via sclr drives device storage only after a subsequent transaction's rck.

Test Plan:
- Reset (WIDTH=8, DIV=2): hold rst 3 cycles -> sclr=0, g=1, sck=rck=0, dready=0 throughout; 1 cycle after release sclr=1, dready=1.
- Load 8'h01, oe=1, chain device model attached -> ser=0,0,0,0,0,0,0,1 at 8 sck rises spaced 4 cycles; rck high at accept+33 for 2 cycles; device q=00000001, g=0.
- Readback: after 8'h01 is loaded, load 8'hFC -> rvalid pulse with rdata=8'h01; device q=11111100.
- Clear then store: clr_req=1 -> sclr low exactly 2 cycles, no sck/rck activity; then load 8'h00 -> rdata=8'h00, device q=00000000.
- Back-to-back and priority: dvalid held high with 8'h0F then 8'hFF -> accepts 35 cycles apart, device q=00001111 then 11111111. Then clr_req=1 and dvalid=1 on the same edge -> CLR taken, word accepted afterwards.
- Abort: assert rst after 3 sck rises of 8'hAA -> next cycle sck=0, sclr=0; no rck pulse; device q keeps its prior value; dready=1 one cycle after rst drops.
